// File: rtl/converter_rx.sv
// converter_rx: decodes one 80-bit block of eight 8B/10B symbols (one per clock) into a 66-bit block.
// Defining ERR_COUNT_EN adds the err_count port with a saturating errored-block counter.
module converter_rx #(
   parameter int unsigned N_SYM = 8,
   parameter int unsigned SYM_W = 10
`ifdef ERR_COUNT_EN
   ,parameter int unsigned ERR_CNT_W = 16
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N_SYM*SYM_W-1:0]   din_80b,
   output logic                     busy,
   output logic [N_SYM*8+1:0]       dout_66b,
   output logic                     dout_valid,
   output logic [N_SYM-1:0]         kout_mask,
   output logic                     code_err,
   output logic                     disp_err,
   output logic                     rd_out
`ifdef ERR_COUNT_EN
   ,output logic [ERR_CNT_W-1:0]    err_count
`endif
);

   localparam int unsigned PAY_W = N_SYM * 8;
   localparam int unsigned IN_W  = N_SYM * SYM_W;
   localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   state_t             state;
   logic [IN_W-1:0]    blk;
   logic [IDX_W-1:0]   idx;
   logic [PAY_W-1:0]   pay_acc;
   logic [N_SYM-1:0]   k_acc;
   logic               code_acc;
   logic               disp_acc;

   // 5b/6b decode: {valid, EDCBA}
   function automatic logic [5:0] dec6(input logic [5:0] c);
      logic [5:0] r;
      r = 6'b0;
      case (c)
         6'b100111, 6'b011000: r = {1'b1, 5'd0};
         6'b011101, 6'b100010: r = {1'b1, 5'd1};
         6'b101101, 6'b010010: r = {1'b1, 5'd2};
         6'b110001:            r = {1'b1, 5'd3};
         6'b110101, 6'b001010: r = {1'b1, 5'd4};
         6'b101001:            r = {1'b1, 5'd5};
         6'b011001:            r = {1'b1, 5'd6};
         6'b111000, 6'b000111: r = {1'b1, 5'd7};
         6'b111001, 6'b000110: r = {1'b1, 5'd8};
         6'b100101:            r = {1'b1, 5'd9};
         6'b010101:            r = {1'b1, 5'd10};
         6'b110100:            r = {1'b1, 5'd11};
         6'b001101:            r = {1'b1, 5'd12};
         6'b101100:            r = {1'b1, 5'd13};
         6'b011100:            r = {1'b1, 5'd14};
         6'b010111, 6'b101000: r = {1'b1, 5'd15};
         6'b011011, 6'b100100: r = {1'b1, 5'd16};
         6'b100011:            r = {1'b1, 5'd17};
         6'b010011:            r = {1'b1, 5'd18};
         6'b110010:            r = {1'b1, 5'd19};
         6'b001011:            r = {1'b1, 5'd20};
         6'b101010:            r = {1'b1, 5'd21};
         6'b011010:            r = {1'b1, 5'd22};
         6'b111010, 6'b000101: r = {1'b1, 5'd23};
         6'b110011, 6'b001100: r = {1'b1, 5'd24};
         6'b100110:            r = {1'b1, 5'd25};
         6'b010110:            r = {1'b1, 5'd26};
         6'b110110, 6'b001001: r = {1'b1, 5'd27};
         6'b001110:            r = {1'b1, 5'd28};
         6'b101110, 6'b010001: r = {1'b1, 5'd29};
         6'b011110, 6'b100001: r = {1'b1, 5'd30};
         6'b101011, 6'b010100: r = {1'b1, 5'd31};
         default:              r = 6'b0;
      endcase
      return r;
   endfunction

   // 3b/4b decode: {valid, HGF}; primary and alternate .7 both accepted
   function automatic logic [3:0] dec4(input logic [3:0] c);
      logic [3:0] r;
      r = 4'b0;
      case (c)
         4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
         4'b1001:                            r = {1'b1, 3'd1};
         4'b0101:                            r = {1'b1, 3'd2};
         4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
         4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
         4'b1010:                            r = {1'b1, 3'd5};
         4'b0110:                            r = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
         default:                            r = 4'b0;
      endcase
      return r;
   endfunction

   logic [5:0]       sym6, r6;
   logic [3:0]       sym4, f4, r4;
   logic [2:0]       ones6, ones4;
   logic             k28, a7, sym_ok, sym_k, sym_derr, rd_mid, rd_nxt;
   logic [7:0]       sym_byte;
   logic [PAY_W-1:0] pay_nxt;
   logic [N_SYM-1:0] k_nxt;
   logic             code_nxt, disp_nxt;
   logic [1:0]       sync_nxt;

   // Decode the current symbol and fold it into the block accumulators
   always_comb begin
      sym6 = blk[SYM_W-1:SYM_W-6];
      sym4 = blk[3:0];
      k28  = (sym6 == 6'b001111) || (sym6 == 6'b110000);
      r6   = k28 ? {1'b1, 5'd28} : dec6(sym6);
      // K28 in its RD+ form carries an inverted 4b group
      f4   = (sym6 == 6'b110000) ? ~sym4 : sym4;
      r4   = dec4(f4);
      a7   = (sym4 == 4'b0111) || (sym4 == 4'b1000);
      sym_ok   = r6[5] & r4[3];
      sym_k    = sym_ok & (k28 | (a7 & ((r6[4:0] == 5'd23) || (r6[4:0] == 5'd27) ||
                                        (r6[4:0] == 5'd29) || (r6[4:0] == 5'd30))));
      sym_byte = sym_ok ? {r4[2:0], r6[4:0]} : 8'h00;
      ones6    = 3'($countones(sym6));
      ones4    = 3'($countones(sym4));
      sym_derr = 1'b0;
      rd_mid   = rd_out;
      if (ones6 == 3'd4) begin
         sym_derr = rd_out;
         rd_mid   = 1'b1;
      end else if (ones6 == 3'd2) begin
         sym_derr = ~rd_out;
         rd_mid   = 1'b0;
      end
      rd_nxt = rd_mid;
      if (ones4 == 3'd3) begin
         sym_derr = sym_derr | rd_mid;
         rd_nxt   = 1'b1;
      end else if (ones4 == 3'd1) begin
         sym_derr = sym_derr | ~rd_mid;
         rd_nxt   = 1'b0;
      end
      if (!sym_ok) begin
         sym_derr = 1'b0;
         rd_nxt   = rd_out;
      end
      pay_nxt  = {sym_byte, pay_acc[PAY_W-1:8]};
      k_nxt    = {sym_k, k_acc[N_SYM-1:1]};
      code_nxt = code_acc | ~sym_ok;
      disp_nxt = disp_acc | sym_derr;
      sync_nxt = code_nxt ? 2'b11 : ((|k_nxt) ? 2'b10 : 2'b01);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         blk        <= '0;
         idx        <= '0;
         pay_acc    <= '0;
         k_acc      <= '0;
         code_acc   <= 1'b0;
         disp_acc   <= 1'b0;
         busy       <= 1'b0;
         dout_66b   <= '0;
         dout_valid <= 1'b0;
         kout_mask  <= '0;
         code_err   <= 1'b0;
         disp_err   <= 1'b0;
         rd_out     <= 1'b0;
`ifdef ERR_COUNT_EN
         err_count  <= '0;
`endif
      end else begin
         dout_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  blk      <= din_80b;
                  idx      <= '0;
                  pay_acc  <= '0;
                  k_acc    <= '0;
                  code_acc <= 1'b0;
                  disp_acc <= 1'b0;
                  busy     <= 1'b1;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               blk      <= blk >> SYM_W;
               idx      <= idx + IDX_W'(1);
               rd_out   <= rd_nxt;
               pay_acc  <= pay_nxt;
               k_acc    <= k_nxt;
               code_acc <= code_nxt;
               disp_acc <= disp_nxt;
               if (idx == IDX_W'(N_SYM - 1)) begin
                  dout_66b   <= {sync_nxt, pay_nxt};
                  kout_mask  <= k_nxt;
                  code_err   <= code_nxt;
                  disp_err   <= disp_nxt;
                  dout_valid <= 1'b1;
                  state      <= DONE;
`ifdef ERR_COUNT_EN
                  if ((code_nxt | disp_nxt) && (err_count != '1))
                     err_count <= err_count + ERR_CNT_W'(1);
`endif
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_converter_rx.sv
// tb_converter_rx: directed vector table, multi-cycle corner sequences and randomized blocks
// checked against a sub-block table decoder with running-disparity model.
module tb_converter_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [79:0] din_80b = '0;
   logic        busy, dout_valid, code_err, disp_err, rd_out;
   logic [65:0] dout_66b;
   logic [7:0]  kout_mask;
`ifdef ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   converter_rx dut (
      .clk(clk), .rst(rst), .en(en), .din_80b(din_80b), .busy(busy),
      .dout_66b(dout_66b), .dout_valid(dout_valid), .kout_mask(kout_mask),
      .code_err(code_err), .disp_err(disp_err), .rd_out(rd_out)
`ifdef ERR_COUNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [9:0] D0M  = 10'b1001110100;
   localparam logic [9:0] D0P  = 10'b0110001011;
   localparam logic [9:0] K28M = 10'b0011111010;

   typedef struct {
      logic [79:0] din;
      logic [65:0] dout;
      logic [7:0]  kmask;
      logic        cerr;
      logic        derr;
      logic        rd;
   } vec_t;

   vec_t        tbl [4];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [5:0]  c6m [32];
   logic [5:0]  c6p [32];
   logic [3:0]  c4m [8];
   logic [3:0]  c4p [8];
   int          d6 [64];
   int          d4 [16];
   bit          m_rd;
   int          m_errs;

   task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en  = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      m_rd   = 1'b0;
      m_errs = 0;
   endtask

   // Start a block and return the cycle (relative to the en cycle) of dout_valid, 0 on timeout
   task automatic run_block(input logic [79:0] d, input bit noisy, output int lat);
      din_80b = d;
      en      = 1'b1;
      lat     = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         step();
         en = (noisy && c <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisy && c <= 8) din_80b = {$urandom, $urandom, 16'($urandom)};
         if (dout_valid === 1'b1) lat = c;
      end
      en = 1'b0;
   endtask

   function automatic bit upd(input bit r, input int n, input int w);
      if (2 * n > w) return 1'b1;
      if (2 * n < w) return 1'b0;
      return r;
   endfunction

   task automatic enc_sym(input logic [7:0] b, input bit k, input bit rdi,
                          output logic [9:0] code, output bit rdo);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] s6;
      logic [3:0] s4, s4b;
      bit         r;
      x = b[4:0];
      y = b[7:5];
      if (k && x == 5'd28) begin
         s4b = (y == 3'd7) ? 4'b1000 : c4p[y];
         s6  = rdi ? 6'b110000 : 6'b001111;
         s4  = rdi ? ~s4b : s4b;
      end else begin
         s6 = rdi ? c6p[x] : c6m[x];
         r  = upd(rdi, $countones(s6), 6);
         if (y == 3'd7 && (k || (!r && (x == 17 || x == 18 || x == 20)) ||
                                (r && (x == 11 || x == 13 || x == 14))))
            s4 = r ? 4'b1000 : 4'b0111;
         else
            s4 = r ? c4p[y] : c4m[y];
      end
      code = {s6, s4};
      rdo  = upd(upd(rdi, $countones(s6), 6), $countones(s4), 4);
   endtask

   // Reference decode of a whole block; advances the model running disparity
   task automatic model_block(input logic [79:0] d, output logic [65:0] dout,
                              output logic [7:0] km, output logic ce, output logic de);
      logic [63:0] pay;
      logic [9:0]  s;
      logic [5:0]  s6;
      logic [3:0]  s4, f4;
      int          x, y, dsp;
      bit          k28, ok, r, e;
      pay = '0;
      km  = '0;
      ce  = 1'b0;
      de  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s   = d[10*i +: 10];
         s6  = s[9:4];
         s4  = s[3:0];
         k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
         f4  = (s6 == 6'b110000) ? ~s4 : s4;
         x   = k28 ? 28 : d6[s6];
         y   = d4[f4];
         ok  = (x >= 0) && (y >= 0);
         if (!ok) begin
            ce = 1'b1;
            continue;
         end
         pay[8*i +: 8] = {3'(y), 5'(x)};
         km[i] = k28 || ((s4 == 4'b0111 || s4 == 4'b1000) &&
                         (x == 23 || x == 27 || x == 29 || x == 30));
         r = m_rd;
         e = 1'b0;
         dsp = 2 * $countones(s6) - 6;
         if (dsp > 0) begin e = e | r;  r = 1'b1; end
         else if (dsp < 0) begin e = e | !r; r = 1'b0; end
         dsp = 2 * $countones(s4) - 4;
         if (dsp > 0) begin e = e | r;  r = 1'b1; end
         else if (dsp < 0) begin e = e | !r; r = 1'b0; end
         m_rd = r;
         de   = de | e;
      end
      dout = {(ce ? 2'b11 : ((|km) ? 2'b10 : 2'b01)), pay};
      if ((ce || de) && m_errs < 65535) m_errs++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          lat, nv, vcyc;
      logic [65:0] cap, edout;
      logic [7:0]  ekm;
      logic        ece, ede;
      logic [79:0] d;
      logic [9:0]  sym;
      logic [4:0]  kx [4];
      logic [7:0]  b;
      bit          erd, k;
      int          r;

      c6m = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
              6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
              6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
              6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
      c6p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
              6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
              6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
              6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
      c4m = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
      c4p = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
      kx  = '{5'd23, 5'd27, 5'd29, 5'd30};
      foreach (d6[i]) d6[i] = -1;
      foreach (d4[i]) d4[i] = -1;
      for (int i = 0; i < 32; i++) begin d6[c6m[i]] = i; d6[c6p[i]] = i; end
      for (int i = 0; i < 8; i++)  begin d4[c4m[i]] = i; d4[c4p[i]] = i; end
      d4[4'b0111] = 7;
      d4[4'b1000] = 7;

      tbl[0] = '{din: {8{D0M}}, dout: {2'b01, 64'h0}, kmask: 8'h00, cerr: 1'b0, derr: 1'b0, rd: 1'b0};
      tbl[1] = '{din: {{7{D0P}}, K28M}, dout: {2'b10, 56'h0, 8'hBC}, kmask: 8'h01,
                 cerr: 1'b0, derr: 1'b0, rd: 1'b1};
      tbl[2] = '{din: {{4{D0M}}, 10'b0000000000, {3{D0M}}}, dout: {2'b11, 64'h0}, kmask: 8'h00,
                 cerr: 1'b1, derr: 1'b0, rd: 1'b0};
      tbl[3] = '{din: {8{D0P}}, dout: {2'b01, 64'h0}, kmask: 8'h00, cerr: 1'b0, derr: 1'b1, rd: 1'b1};

      do_reset();
      chk("reset_busy", 66'(busy), 66'(0));
      chk("reset_valid", 66'(dout_valid), 66'(0));
      chk("reset_dout", dout_66b, 66'(0));
      chk("reset_flags", 66'({kout_mask, code_err, disp_err, rd_out}), 66'(0));
`ifdef ERR_COUNT_EN
      chk("reset_err_count", 66'(err_count), 66'(0));
`endif

      foreach (tbl[v]) begin
         do_reset();
         run_block(tbl[v].din, 1'b0, lat);
         chk($sformatf("v%0d_latency", v), 66'(lat), 66'(9));
         chk($sformatf("v%0d_dout", v), dout_66b, tbl[v].dout);
         chk($sformatf("v%0d_kmask", v), 66'(kout_mask), 66'(tbl[v].kmask));
         chk($sformatf("v%0d_code_err", v), 66'(code_err), 66'(tbl[v].cerr));
         chk($sformatf("v%0d_disp_err", v), 66'(disp_err), 66'(tbl[v].derr));
         chk($sformatf("v%0d_rd", v), 66'(rd_out), 66'(tbl[v].rd));
         step();
         chk($sformatf("v%0d_valid_pulse", v), 66'({dout_valid, busy}), 66'(0));
         chk($sformatf("v%0d_dout_hold", v), dout_66b, tbl[v].dout);
      end

      // en at cycles 0, 3 and 5: only the first block is taken
      do_reset();
      nv = 0; vcyc = -1; cap = '0;
      for (int c = 0; c <= 14; c++) begin
         if (c > 0 && dout_valid === 1'b1) begin nv++; vcyc = c; cap = dout_66b; end
         if (c == 3 || c == 5) chk($sformatf("busy_c%0d", c), 66'(busy), 66'(1));
         en = (c == 0 || c == 3 || c == 5);
         if (c == 0) din_80b = tbl[1].din;
         if (c == 3) din_80b = tbl[0].din;
         if (c == 5) din_80b = tbl[3].din;
         step();
      end
      en = 1'b0;
      chk("ignored_en_count", 66'(nv), 66'(1));
      chk("ignored_en_cycle", 66'(vcyc), 66'(9));
      chk("ignored_en_data", cap, tbl[1].dout);

      // Reset in the middle of a block
      din_80b = tbl[2].din;
      en = 1'b1;
      step();
      en = 1'b0;
      step(); step(); step();
      rst = 1'b0;
      #1;
      chk("midrst_dout", dout_66b, 66'(0));
      chk("midrst_state", 66'({busy, kout_mask, code_err, disp_err, rd_out}), 66'(0));
      step(); step();
      rst = 1'b1;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (dout_valid === 1'b1) nv++;
      end
      chk("midrst_no_valid", 66'(nv), 66'(0));
      m_rd = 1'b0;
      m_errs = 0;

`ifdef ERR_COUNT_EN
      // Two errored blocks, then a clean block encoded from the RD+ left behind
      do_reset();
      run_block(tbl[2].din, 1'b0, lat); step();
      run_block(tbl[3].din, 1'b0, lat); step();
      run_block({8{D0P}}, 1'b0, lat);
      chk("cnt_clean_disp", 66'(disp_err), 66'(0));
      chk("cnt_err_count", 66'(err_count), 66'(2));
      step();
`endif

      do_reset();
      erd = 1'b0;
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
               sym = 10'($urandom);
            end else begin
               k = (r <= 3);
               if (k) begin
                  r = $urandom_range(0, 11);
                  b = (r < 8) ? {3'(r), 5'd28} : {3'd7, kx[r-8]};
               end else begin
                  b = 8'($urandom);
               end
               enc_sym(b, k, (r == 19) ? !erd : erd, sym, erd);
            end
            d[10*i +: 10] = sym;
         end
         model_block(d, edout, ekm, ece, ede);
         run_block(d, (n % 3) == 1, lat);
         chk($sformatf("rnd%0d_latency", n), 66'(lat), 66'(9));
         chk($sformatf("rnd%0d_dout", n), dout_66b, edout);
         chk($sformatf("rnd%0d_flags", n), 66'({kout_mask, code_err, disp_err, rd_out}),
             66'({ekm, ece, ede, m_rd}));
`ifdef ERR_COUNT_EN
         chk($sformatf("rnd%0d_err_count", n), 66'(err_count), 66'(m_errs));
`endif
         step();
         repeat ($urandom_range(0, 2)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
